// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage that sits just upstream of a byte-addressed
// instruction memory with a one-cycle registered read.
//
// It owns the PC, drives the memory's read address, and presents a registered
// instruction, its PC and a valid flag to decode. A one-entry skid buffer keeps
// the in-flight read while decode is stalled. A redirect squashes all wrong-path
// work and restarts fetch at the target.
//
// Ports:
//   clk           rising-edge clock, shared with the instruction memory
//   rst_n         asynchronous active-low reset
//   stall         decode cannot accept; outputs hold
//   redirect      load redirect_addr into the PC and squash in-flight work
//   redirect_addr redirect target; the low two bits are forced to zero
//   read_address  byte address sent to memory (equal to pc)
//   imem_data     memory output, mem[address presented at the previous edge]
//   instr         registered instruction to decode
//   instr_pc      byte address of instr
//   instr_valid   instr is a valid, non-squashed instruction
module fetch_unit #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int RESET_PC = 0,
   parameter int PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic [ADDR_W-1:0] read_address,
   input  logic [DATA_W-1:0] imem_data,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid
);

   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pend_pc;     // address whose data is on imem_data this cycle
   logic              pend_valid;
   logic [ADDR_W-1:0] skid_pc;
   logic [DATA_W-1:0] skid_instr;
   logic              skid_valid;

   assign read_address = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= ADDR_W'(RESET_PC);
         pend_pc     <= '0;
         pend_valid  <= 1'b0;
         skid_pc     <= '0;
         skid_instr  <= '0;
         skid_valid  <= 1'b0;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
      end else if (redirect) begin
         // Redirect wins over stall. Everything in flight belongs to the wrong path.
         // instr and instr_pc keep their values, but instr_valid drops to 0.
         pc          <= {redirect_addr[ADDR_W-1:2], 2'b00};
         pend_valid  <= 1'b0;
         skid_valid  <= 1'b0;
         instr_valid <= 1'b0;
      end else if (stall) begin
         // The memory re-reads on every edge. Pending data has to be caught now
         // or it is lost. pc holds, so the same address is re-issued on release.
         if (pend_valid && !skid_valid) begin
            skid_instr <= imem_data;
            skid_pc    <= pend_pc;
            skid_valid <= 1'b1;
         end
         pend_valid <= 1'b0;
      end else begin
         if (skid_valid) begin
            instr       <= skid_instr;
            instr_pc    <= skid_pc;
            instr_valid <= 1'b1;
            skid_valid  <= 1'b0;
         end else begin
            instr       <= imem_data;
            instr_pc    <= pend_pc;
            instr_valid <= pend_valid;
         end
         pend_pc    <= pc;
         pend_valid <= 1'b1;
         pc         <= pc + ADDR_W'(PC_STEP);   // modulo 2^ADDR_W wrap
      end
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the byte-addressed instruction memory.
- Owns the program counter and drives the memory's read address.
- Compensates for the memory's one-cycle registered read latency.
- Presents an IF/ID-style registered instruction, with its PC and a valid flag, to decode.
- Supports decode stall (via a one-entry skid buffer) and branch/jump redirect with squash of wrong-path fetches.

Parameters:
ADDR_W, 6, width of the instruction byte address / PC
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded on reset
PC_STEP, 4, bytes per instruction

Ports:
clk  input  1  rising-edge clock shared with the instruction memory
rst_n  input  1  asynchronous active-low reset
stall  input  1  decode cannot accept; hold outputs
redirect  input  1  load redirect_addr into PC, squash in-flight work
redirect_addr  input  ADDR_W  redirect target; bits [1:0] ignored (forced 0)
read_address  output  ADDR_W  registered byte address to instruction memory (= pc)
imem_data  input  DATA_W  memory output; equals mem[address presented at previous edge]
instr  output  DATA_W  registered instruction to decode
instr_pc  output  ADDR_W  byte address of instr
instr_valid  output  1  instr is a valid, non-squashed instruction

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low on rst_n.
- State:
  - pc: address presented this cycle.
  - pend_valid/pend_pc: imem_data this cycle is mem[pend_pc].
  - skid_valid/skid_instr/skid_pc: one-entry holding buffer.
- Reset (rst_n=0, async): pc=RESET_PC; pend_valid=0; skid_valid=0; instr=0; instr_pc=0; instr_valid=0; pend_pc=0; skid_pc=0; skid_instr=0.
- Per rising edge, priority redirect > stall > advance.
- REDIRECT:
  - pc<=redirect_addr with [1:0]=0.
  - pend_valid<=0, skid_valid<=0, instr_valid<=0; instr/instr_pc hold.
  - Redirect wins even while stalled.
- STALL (no redirect):
  - instr, instr_pc, instr_valid hold; pc holds.
  - If pend_valid && !skid_valid: skid_instr<=imem_data, skid_pc<=pend_pc, skid_valid<=1, pend_valid<=0.
  - Otherwise pend_valid<=0 and skid holds.
  - Rationale: the memory re-reads every edge, so pending data must be captured or it is lost.
- ADVANCE (neither):
  - If skid_valid: instr<=skid_instr, instr_pc<=skid_pc, instr_valid<=1, skid_valid<=0.
  - Else: instr<=imem_data, instr_pc<=pend_pc, instr_valid<=pend_valid.
  - Issue: pend_pc<=pc, pend_valid<=1, pc<=pc+PC_STEP.
- Invariant: skid_valid and pend_valid are never both 1.
- PC arithmetic: ADDR_W-bit modulo; 60+4 wraps to 0 with no flag.
- Latency:
  - An address issued at edge N appears on instr at edge N+1 when unstalled.
  - After reset release: edge1 issues RESET_PC, edge2 sets instr_valid=1 with mem[RESET_PC].
  - After redirect at edge R: target is presented at R, issued at R+1, valid on instr at R+2 (two bubble cycles).
- Stall release: skid contents drain at the first advance edge, then sequential fetch continues with no bubble.
- Stall of 1 cycle or many cycles behaves identically; no instruction is lost or duplicated.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately.

Test Plan:
- Reset then free-run, memory preloaded with word k at address 4k → instr_valid rises at edge2; instr_pc sequence 0,4,8,…; instr = word0, word1, … one per cycle.
- Free-run through address 60 → instr_pc 60 followed by 0; read_address wraps 60→0 with no glitch.
- stall high for 3 cycles once instr_pc=8 → instr holds word2 for 3 cycles; after release instr_pc runs 12,16,… with no gap or duplicate (skid path exercised).
- redirect with redirect_addr=0x21 at instr_pc=8 → next two edges have instr_valid=0; third edge gives instr_pc=0x20 with mem[0x20]; wrong-path 12 and 16 are never valid.
- redirect and stall asserted together while skid_valid=1 → skid discarded, instr_valid=0, fetch resumes at the target.
- rst_n pulsed low asynchronously mid-stall → outputs go to 0 and instr_valid to 0 immediately; sequence restarts at RESET_PC.
